// File: rtl/risc_trace_pkg.sv
// Shared definitions for the KGP-RISC trace capture block: record layout,
// word-index constants, stream FSM encoding and record pack/unpack helpers.
package risc_trace_pkg;

    localparam int REC_WORDS = 5;
    localparam int REC_W     = 160;

    localparam logic [2:0] W_ADDR  = 3'd0;
    localparam logic [2:0] W_INSTR = 3'd1;
    localparam logic [2:0] W_ALU   = 3'd2;
    localparam logic [2:0] W_WDATA = 3'd3;
    localparam logic [2:0] W_MRD   = 3'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // Word 0 sits in the top bits so the record reads in stream order.
    function automatic logic [REC_W-1:0] pack_rec(
        input logic [31:0] addr,
        input logic [31:0] instr,
        input logic [31:0] alu,
        input logic [31:0] wdata,
        input logic [31:0] mrdata
    );
        pack_rec = {addr, instr, alu, wdata, mrdata};
    endfunction

    function automatic logic [31:0] rec_word(
        input logic [REC_W-1:0] rec,
        input logic [2:0]       idx
    );
        case (idx)
            W_ADDR:  rec_word = rec[159:128];
            W_INSTR: rec_word = rec[127:96];
            W_ALU:   rec_word = rec[95:64];
            W_WDATA: rec_word = rec[63:32];
            W_MRD:   rec_word = rec[31:0];
            default: rec_word = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/risc_trace_capture_fifo.sv
// Record FIFO for the trace capture block. Exposes the head record and the
// record behind it so the streamer can start the next record without a bubble.
module trace_fifo
    import risc_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [REC_W-1:0]         din,
    output logic [REC_W-1:0]         dout,
    output logic [REC_W-1:0]         dout_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [REC_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W-1:0] rd_next_s;
    logic             wr_en_s;
    logic             rd_en_s;

    // A full FIFO may still take a push when the head leaves on the same edge.
    assign wr_en_s   = push && (!full || rd_en_s);
    assign rd_en_s   = pop && !empty;
    assign rd_next_s = rd_ptr_r + PTR_ONE;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign dout_next = mem_r[rd_next_s];

    // Record storage, no reset needed: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_next_s;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/risc_trace_capture.sv
// Observation-port consumer: captures one 5-word record per new instruction
// address and drains records as a 32-bit valid/ready word stream.
module risc_trace_capture
    import risc_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic [31:0]              Oinstruct,
    input  logic [31:0]              OinstrAddr,
    input  logic [31:0]              OwriteData,
    input  logic [31:0]              OaluResult,
    input  logic [31:0]              OmemreadData,
    output logic [31:0]              m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic              first_r;
    logic [31:0]       last_addr_r;
    logic [DROP_W-1:0] drop_cnt_r;
    logic              overflow_r;
    state_t            state_r;
    logic [2:0]        idx_r;
    logic [31:0]       m_data_r;
    logic              m_valid_r;
    logic              m_last_r;

    logic              new_s;
    logic              beat_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic [2:0]        idx_inc_s;
    logic [REC_W-1:0]  rec_s;
    logic [REC_W-1:0]  head_s;
    logic [REC_W-1:0]  next_s;
    logic              full_s;
    logic              empty_s;
    logic [CNT_W-1:0]  count_s;

    // Change detection, push acceptance and drop decision for this edge.
    always_comb begin
        new_s     = trace_en && (first_r || (OinstrAddr != last_addr_r));
        beat_s    = m_valid_r && m_ready;
        pop_s     = beat_s && (idx_r == W_MRD);
        push_s    = new_s && (!full_s || pop_s);
        drop_s    = new_s && !push_s;
        idx_inc_s = idx_r + 3'd1;
        rec_s     = pack_rec(OinstrAddr, Oinstruct, OaluResult, OwriteData, OmemreadData);
    end

    trace_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .din       (rec_s),
        .dout      (head_s),
        .dout_next (next_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Last-seen address tracking; a dropped record still counts as seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_r     <= 1'b1;
            last_addr_r <= 32'd0;
        end else if (new_s) begin
            first_r     <= 1'b0;
            last_addr_r <= OinstrAddr;
        end else begin
            first_r     <= first_r;
            last_addr_r <= last_addr_r;
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= '0;
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != DROP_MAX) begin
                drop_cnt_r <= drop_cnt_r + DROP_ONE;
            end
        end else begin
            drop_cnt_r <= drop_cnt_r;
            overflow_r <= overflow_r;
        end
    end

    // Stream FSM: the next word is loaded into the output register ahead of time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            idx_r     <= W_ADDR;
            m_data_r  <= 32'd0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    idx_r    <= W_ADDR;
                    m_last_r <= 1'b0;
                    if (!empty_s) begin
                        state_r   <= S_SEND;
                        m_valid_r <= 1'b1;
                        m_data_r  <= rec_word(head_s, W_ADDR);
                    end else if (push_s) begin
                        state_r   <= S_SEND;
                        m_valid_r <= 1'b1;
                        m_data_r  <= OinstrAddr;
                    end
                end
                S_SEND: begin
                    if (beat_s) begin
                        if (idx_r == W_MRD) begin
                            idx_r    <= W_ADDR;
                            m_last_r <= 1'b0;
                            // Behind the head is either a stored record or the one arriving now.
                            if (count_s > CNT_ONE) begin
                                m_data_r <= rec_word(next_s, W_ADDR);
                            end else if (push_s) begin
                                m_data_r <= OinstrAddr;
                            end else begin
                                state_r   <= S_IDLE;
                                m_valid_r <= 1'b0;
                                m_data_r  <= 32'd0;
                            end
                        end else begin
                            idx_r    <= idx_inc_s;
                            m_data_r <= rec_word(head_s, idx_inc_s);
                            m_last_r <= (idx_inc_s == W_MRD);
                        end
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    idx_r     <= W_ADDR;
                    m_data_r  <= 32'd0;
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign m_data     = m_data_r;
    assign m_valid    = m_valid_r;
    assign m_last     = m_last_r;
    assign fifo_count = count_s;
    assign drop_cnt   = drop_cnt_r;
    assign overflow   = overflow_r;

endmodule
